// File: rtl/sha3_pad_pack.sv
// rtl/sha3_pad_pack.sv - byte-serial SHA-3 pad10*1 packer emitting 25-lane Keccak frames
// Optional block counter output enabled by SHA3_PAD_BLKCNT_EN.
module sha3_pad_pack #(
    parameter int          RATE_LANES = 17,
    parameter logic [7:0]  DOMAIN     = 8'h06
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pushin,
    output logic        stopin,
    input  logic        firstin,
    input  logic        lastin,
    input  logic        zlenin,
    input  logic [7:0]  din,
    output logic        pushout,
    input  logic        stopout,
    output logic        firstout,
    output logic        lastout,
`ifdef SHA3_PAD_BLKCNT_EN
    output logic [15:0] blkcnt,
`endif
    output logic [63:0] dout
);

    localparam int CAP_LANES = 25 - RATE_LANES;
    localparam logic [4:0] LAST_RATE = 5'(RATE_LANES - 1);
    localparam logic [4:0] LAST_CAP  = 5'(CAP_LANES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ABSORB, S_PAD, S_FILL} state_t;

    state_t      state_q, state_d;
    logic [2:0]  bi_q, bi_d;
    logic [4:0]  li_q, li_d;
    logic [63:0] pack_q, pack_d;
    logic        final_q, final_d;
    logic        pend_q, pend_d;
    logic [63:0] dout_q, dout_d;
    logic        pushout_q, pushout_d;
    logic        firstout_q, firstout_d;
    logic        lastout_q, lastout_d;

    logic        accept, out_free, load, lane_first, lane_last;
    logic [63:0] lane, pw;
    logic [2:0]  bidx;
    logic [4:0]  lidx;

    assign out_free = !pushout_q || !stopout;
    assign accept   = pushin && !stopin;
    assign bidx     = firstin ? 3'd0 : bi_q;
    assign lidx     = firstin ? 5'd0 : li_q;

    always_comb begin
        state_d    = state_q;
        bi_d       = bi_q;
        li_d       = li_q;
        pack_d     = pack_q;
        final_d    = final_q;
        pend_d     = pend_q;
        stopin     = 1'b0;
        load       = 1'b0;
        lane       = 64'd0;
        lane_first = 1'b0;
        lane_last  = 1'b0;
        pw         = firstin ? 64'd0 : pack_q;

        // A lane-completing byte is refused while the output register cannot take it.
        if (state_q == S_ABSORB)
            stopin = (bi_q == 3'd7) && pushout_q && stopout;
        else if (state_q == S_PAD || state_q == S_FILL)
            stopin = 1'b1;

        case (state_q)
            S_IDLE, S_ABSORB: begin
                if (accept && (firstin || state_q == S_ABSORB)) begin
                    if (firstin && lastin && zlenin) begin
                        pack_d  = {56'd0, DOMAIN};
                        bi_d    = 3'd0;
                        li_d    = 5'd0;
                        state_d = S_PAD;
                    end else begin
                        pw[{bidx, 3'b000} +: 8] = din;
                        if (bidx == 3'd7) begin
                            load       = 1'b1;
                            lane       = pw;
                            lane_first = (lidx == 5'd0);
                            pack_d     = 64'd0;
                            bi_d       = 3'd0;
                            if (lidx == LAST_RATE) begin
                                li_d    = 5'd0;
                                final_d = 1'b0;
                                pend_d  = lastin;
                                state_d = S_FILL;
                            end else begin
                                li_d    = lidx + 5'd1;
                                state_d = lastin ? S_PAD : S_ABSORB;
                                if (lastin)
                                    pack_d[7:0] = DOMAIN;
                            end
                        end else begin
                            if (lastin)
                                pw[{bidx + 3'd1, 3'b000} +: 8] = DOMAIN;
                            pack_d  = pw;
                            bi_d    = bidx + 3'd1;
                            li_d    = lidx;
                            state_d = lastin ? S_PAD : S_ABSORB;
                        end
                    end
                end
            end
            S_PAD: begin
                if (out_free) begin
                    load       = 1'b1;
                    lane       = pack_q;
                    lane_first = (li_q == 5'd0);
                    pack_d     = 64'd0;
                    bi_d       = 3'd0;
                    if (li_q == LAST_RATE) begin
                        lane[63:56] = pack_q[63:56] | 8'h80;
                        li_d        = 5'd0;
                        final_d     = 1'b1;
                        state_d     = S_FILL;
                    end else begin
                        li_d = li_q + 5'd1;
                    end
                end
            end
            S_FILL: begin
                if (out_free) begin
                    load = 1'b1;
                    if (li_q == LAST_CAP) begin
                        li_d = 5'd0;
                        if (final_q) begin
                            lane_last = 1'b1;
                            state_d   = S_IDLE;
                        end else if (pend_q) begin
                            // Message ended exactly on a block boundary: open a padding-only block.
                            pack_d  = {56'd0, DOMAIN};
                            pend_d  = 1'b0;
                            state_d = S_PAD;
                        end else begin
                            state_d = S_ABSORB;
                        end
                    end else begin
                        li_d = li_q + 5'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        dout_d     = load ? lane : dout_q;
        firstout_d = load ? lane_first : firstout_q;
        lastout_d  = load ? lane_last : lastout_q;
        pushout_d  = load || (pushout_q && stopout);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bi_q       <= 3'd0;
            li_q       <= 5'd0;
            pack_q     <= 64'd0;
            final_q    <= 1'b0;
            pend_q     <= 1'b0;
            dout_q     <= 64'd0;
            pushout_q  <= 1'b0;
            firstout_q <= 1'b0;
            lastout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bi_q       <= bi_d;
            li_q       <= li_d;
            pack_q     <= pack_d;
            final_q    <= final_d;
            pend_q     <= pend_d;
            dout_q     <= dout_d;
            pushout_q  <= pushout_d;
            firstout_q <= firstout_d;
            lastout_q  <= lastout_d;
        end
    end

    assign pushout  = pushout_q;
    assign firstout = firstout_q;
    assign lastout  = lastout_q;
    assign dout     = dout_q;

`ifdef SHA3_PAD_BLKCNT_EN
    logic [15:0] blkcnt_q, blkcnt_d;

    always_comb begin
        blkcnt_d = blkcnt_q;
        if (accept && firstin)
            blkcnt_d = 16'd0;
        else if (pushout_q && !stopout && firstout_q && blkcnt_q != 16'hFFFF)
            blkcnt_d = blkcnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            blkcnt_q <= 16'd0;
        else
            blkcnt_q <= blkcnt_d;
    end

    assign blkcnt = blkcnt_q;
`endif

endmodule

// File: tb/tb_sha3_pad_pack.sv
// tb/tb_sha3_pad_pack.sv - randomized scoreboard bench for sha3_pad_pack
module tb_sha3_pad_pack;
    localparam int         RATE = 17;
    localparam logic [7:0] DOM  = 8'h06;

    logic        clk = 1'b0, rst = 1'b1;
    logic        pushin = 1'b0, firstin = 1'b0, lastin = 1'b0, zlenin = 1'b0;
    logic        stopout = 1'b0;
    logic [7:0]  din = 8'd0;
    logic        stopin, pushout, firstout, lastout;
    logic [63:0] dout;
`ifdef SHA3_PAD_BLKCNT_EN
    logic [15:0] blkcnt;
    int          exp_blk = 0;
`endif

    int          checks = 0, errors = 0;
    logic [65:0] expq[$];
    logic [7:0]  msg[$];
    bit          stall_en = 1'b0, did_long = 1'b0, held_valid = 1'b0;
    int          stall_cnt = 0, nlanes = 0;
    logic [65:0] held;

    sha3_pad_pack #(.RATE_LANES(RATE), .DOMAIN(DOM)) dut (
        .clk(clk), .rst(rst), .pushin(pushin), .stopin(stopin),
        .firstin(firstin), .lastin(lastin), .zlenin(zlenin), .din(din),
        .pushout(pushout), .stopout(stopout), .firstout(firstout),
        .lastout(lastout),
`ifdef SHA3_PAD_BLKCNT_EN
        .blkcnt(blkcnt),
`endif
        .dout(dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: message ++ DOMAIN, zero-pad to a rate multiple, set top bit of last rate byte.
    task automatic model_push(input int len);
        int rb, plen, nblk;
        logic [7:0]  p[];
        logic [63:0] w;
        rb   = RATE * 8;
        plen = ((len + 1 + rb - 1) / rb) * rb;
        p    = new[plen];
        for (int i = 0; i < plen; i++) p[i] = (i < len) ? msg[i] : 8'h00;
        p[len]      = p[len] | DOM;
        p[plen - 1] = p[plen - 1] | 8'h80;
        nblk = plen / rb;
        for (int b = 0; b < nblk; b++)
            for (int l = 0; l < 25; l++) begin
                w = 64'd0;
                if (l < RATE)
                    for (int k = 0; k < 8; k++) w[8*k +: 8] = p[b*rb + l*8 + k];
                expq.push_back({w, l == 0, (b == nblk - 1) && (l == 24)});
            end
    endtask

    task automatic beat(input logic [7:0] d, input logic f, input logic l, input logic z);
        bit acc, ok;
        ok = 1'b0;
        pushin = 1'b1; din = d; firstin = f; lastin = l; zlenin = z;
        if ($urandom_range(0, 9) < 2) begin
            pushin = 1'b0;
            @(posedge clk); #1;
            pushin = 1'b1;
        end
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            acc = !stopin;
            @(posedge clk); #1;
            if (acc) begin ok = 1'b1; break; end
        end
`ifdef SHA3_PAD_BLKCNT_EN
        if (ok && f) exp_blk = 0;
`endif
        if (!ok) begin
            errors++;
            $display("FAIL beat_accept: stopin stuck for 2000 cycles");
        end
        pushin = 1'b0; firstin = 1'b0; lastin = 1'b0; zlenin = 1'b0;
    endtask

    task automatic send_msg(input int len);
        if (len == 0) begin
            beat($urandom_range(0, 255), 1'b1, 1'b1, 1'b1);
        end else begin
            for (int i = 0; i < len; i++)
                beat(msg[i], i == 0, i == len - 1, 1'b0);
        end
    endtask

    task automatic run_msg(input int len, input int pattern);
        msg.delete();
        for (int i = 0; i < len; i++)
            msg.push_back(pattern >= 0 ? 8'(pattern) : 8'($urandom_range(0, 255)));
        model_push(len);
        send_msg(len);
    endtask

    // Downstream stall generator, including one long stall on lane 3.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!did_long && stall_en && nlanes == 3 && pushout) begin
                did_long  = 1'b1;
                stall_cnt = 5;
            end
            if (stall_cnt > 0) begin
                stopout = 1'b1;
                stall_cnt--;
            end else begin
                stopout = stall_en && ($urandom_range(0, 99) < 25);
            end
        end
    end

    // Monitor: hold checks during stalls and scoreboard compare on each transfer.
    always @(negedge clk) begin
        if (rst) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid && pushout)
                chk("hold_stable", {dout, firstout, lastout}, held);
            else if (held_valid)
                chk("hold_pushout", {65'd0, pushout}, 66'd1);
            held_valid = pushout && stopout;
            held       = {dout, firstout, lastout};
            if (pushout && !stopout) begin
                nlanes++;
`ifdef SHA3_PAD_BLKCNT_EN
                if (firstout && exp_blk != 65535) exp_blk++;
`endif
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_lane: got %h with nothing expected", dout);
                end else begin
                    chk("lane", {dout, firstout, lastout}, expq.pop_front());
                end
            end
        end
    end

    initial begin
        int lens[9] = '{1, 7, 8, 134, 135, 136, 137, 271, 272};
        #2;
        @(negedge clk);
        chk("rst_pushout",  {65'd0, pushout},  66'd0);
        chk("rst_stopin",   {65'd0, stopin},   66'd0);
        chk("rst_firstout", {65'd0, firstout}, 66'd0);
        chk("rst_lastout",  {65'd0, lastout},  66'd0);
        chk("rst_dout",     {2'd0, dout},      66'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        stall_en = 1'b1;

        run_msg(0, 0);
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        model_push(3);
        send_msg(3);
        run_msg(135, 8'hAA);
        run_msg(136, -1);

        // Abort after 20 bytes: only the two completed lanes may appear.
        stall_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        msg.delete();
        for (int i = 0; i < 20; i++) msg.push_back(8'($urandom_range(0, 255)));
        for (int l = 0; l < 2; l++)
            expq.push_back({msg[8*l+7], msg[8*l+6], msg[8*l+5], msg[8*l+4],
                            msg[8*l+3], msg[8*l+2], msg[8*l+1], msg[8*l], l == 0, 1'b0});
        for (int i = 0; i < 20; i++) beat(msg[i], i == 0, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_drained", 66'(expq.size()), 66'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_pushout", {65'd0, pushout}, 66'd0);
        chk("midrst_dout",    {2'd0, dout},     66'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) beat(8'h55, 1'b0, 1'b0, 1'b0);
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        model_push(3);
        stall_en = 1'b1;
        send_msg(3);

        foreach (lens[i]) run_msg(lens[i], -1);
        for (int m = 0; m < 8; m++) run_msg($urandom_range(0, 300), -1);

        for (int t = 0; t < 5000 && expq.size() != 0; t++) @(posedge clk);
        stall_en = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("drain_queue", 66'(expq.size()), 66'd0);
        chk("final_idle_pushout", {65'd0, pushout}, 66'd0);
        chk("long_stall_seen", {65'd0, did_long}, 66'd1);
`ifdef SHA3_PAD_BLKCNT_EN
        chk("blkcnt", {50'd0, blkcnt}, 66'(exp_blk));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
